alu_pipelined: RTL and testbench

//  Integer execute unit for the in-order core: ALU ops, branch compare, jump target gen.

---
 rtl/alu_pipelined_pkg.sv | 44 ++++
 rtl/alu_pipelined_queue.sv | 60 ++++++
 rtl/alu_pipelined.sv | 235 +++++++++++++++++++++++
 tb/tb_alu_pipelined.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipelined_pkg.sv
// Shared encodings for the integer execute unit: unit/sub-unit ids, op selects, FSM states.
package alu_pipelined_pkg;

    localparam logic [1:0] UNIT_ALU = 2'h0;

    typedef enum logic [2:0] {
        SUB_UPPER  = 3'd0,
        SUB_BRANCH = 3'd1,
        SUB_ADDSUB = 3'd2,
        SUB_CMPLOG = 3'd3,
        SUB_SHIFT  = 3'd4
    } alu_sub_e;

    localparam logic [3:0] SEL_LUI   = 4'd0;
    localparam logic [3:0] SEL_AUIPC = 4'd1;
    localparam logic [3:0] SEL_JAL   = 4'd2;
    localparam logic [3:0] SEL_JALR  = 4'd3;

    localparam logic [3:0] SEL_BEQ  = 4'd0;
    localparam logic [3:0] SEL_BNE  = 4'd1;
    localparam logic [3:0] SEL_BLT  = 4'd2;
    localparam logic [3:0] SEL_BGE  = 4'd3;
    localparam logic [3:0] SEL_BLTU = 4'd4;
    localparam logic [3:0] SEL_BGEU = 4'd5;

    localparam logic [3:0] SEL_ADD = 4'd0;
    localparam logic [3:0] SEL_SUB = 4'd1;

    localparam logic [3:0] SEL_SLT  = 4'd0;
    localparam logic [3:0] SEL_SLTU = 4'd1;
    localparam logic [3:0] SEL_XOR  = 4'd2;
    localparam logic [3:0] SEL_OR   = 4'd3;
    localparam logic [3:0] SEL_AND  = 4'd4;

    localparam logic [3:0] SEL_SLL = 4'd0;
    localparam logic [3:0] SEL_SRL = 4'd1;
    localparam logic [3:0] SEL_SRA = 4'd2;

    typedef enum logic {
        FSM_IDLE,
        FSM_SHIFT
    } shift_state_e;

endpackage

// File: rtl/alu_pipelined_queue.sv
// Circular result queue toward write-back; pop on empty is ignored and flush empties it.
module alu_out_queue #(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = logic
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  entry_t                       push_data,
    input  logic                         pop,
    output entry_t                       head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign do_push = push & (count != CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: every visible field is gated by queue occupancy.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_pipelined.sv
// Integer execute unit: ALU ops, branch compare, jump targets, optional bit-serial shifter,
// results delivered through a small output queue with illegal-op reporting.
module alu_pipelined
    import alu_pipelined_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned OUT_DEPTH    = 2,
    parameter bit          SERIAL_SHIFT = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      unit,
    input  logic [2:0]      sub_unit,
    input  logic [3:0]      sel,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] immediate,
    input  logic            imm,
    input  logic [XLEN-1:0] pc,
    input  logic [4:0]      rd_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] target,
    output logic            target_valid,
    output logic            illegal,
    input  logic            flush
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = $clog2(OUT_DEPTH + 1);

    typedef struct packed {
        logic            target_valid;
        logic            result_valid;
        logic            illegal;
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] target;
    } alu_entry_t;

    shift_state_e    state_q, state_d;
    logic            ready_en_q;
    logic [CW-1:0]   q_count;
    logic            q_empty;
    alu_entry_t      dec_e, push_e, head_e;
    logic            dec_illegal, dec_serial, taken;
    logic            accept, push;
    logic [XLEN-1:0] opb;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sh_val, sh_step;
    logic [1:0]      sh_op;
    logic [4:0]      sh_rd;
    logic [SHW-1:0]  sh_cnt;

    // ready_en_q keeps in_ready low during reset without a comb path from rst_n.
    assign in_ready = ready_en_q & (q_count < CW'(OUT_DEPTH)) & (state_q == FSM_IDLE) & ~flush;
    assign accept   = in_valid & in_ready & (unit == UNIT_ALU);

    always_comb begin
        dec_e       = '0;
        dec_e.rd    = rd_i;
        dec_illegal = 1'b0;
        dec_serial  = 1'b0;
        taken       = 1'b0;
        opb         = imm ? immediate : rs2;
        shamt       = opb[SHW-1:0];
        case (alu_sub_e'(sub_unit))
            SUB_UPPER: begin
                dec_e.result_valid = 1'b1;
                case (sel)
                    SEL_LUI:   dec_e.result = immediate;
                    SEL_AUIPC: dec_e.result = pc + immediate;
                    SEL_JAL: begin
                        dec_e.result       = pc + XLEN'(4);
                        dec_e.target       = pc + immediate;
                        dec_e.target_valid = 1'b1;
                    end
                    SEL_JALR: begin
                        dec_e.result       = pc + XLEN'(4);
                        dec_e.target       = (rs1 + immediate) & ~XLEN'(1);
                        dec_e.target_valid = 1'b1;
                    end
                    default:   dec_illegal = 1'b1;
                endcase
            end
            SUB_BRANCH: begin
                case (sel)
                    SEL_BEQ:  taken = (rs1 == rs2);
                    SEL_BNE:  taken = (rs1 != rs2);
                    SEL_BLT:  taken = ($signed(rs1) < $signed(rs2));
                    SEL_BGE:  taken = ($signed(rs1) >= $signed(rs2));
                    SEL_BLTU: taken = (rs1 < rs2);
                    SEL_BGEU: taken = (rs1 >= rs2);
                    default:  dec_illegal = 1'b1;
                endcase
                dec_e.target_valid = taken;
                if (taken) dec_e.target = pc + immediate;
            end
            SUB_ADDSUB: begin
                dec_e.result_valid = 1'b1;
                case (sel)
                    SEL_ADD: dec_e.result = rs1 + opb;
                    SEL_SUB: begin
                        if (imm) dec_illegal = 1'b1;
                        else     dec_e.result = rs1 - rs2;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            SUB_CMPLOG: begin
                dec_e.result_valid = 1'b1;
                case (sel)
                    SEL_SLT:  dec_e.result = XLEN'($signed(rs1) < $signed(opb));
                    SEL_SLTU: dec_e.result = XLEN'(rs1 < opb);
                    SEL_XOR:  dec_e.result = rs1 ^ opb;
                    SEL_OR:   dec_e.result = rs1 | opb;
                    SEL_AND:  dec_e.result = rs1 & opb;
                    default:  dec_illegal = 1'b1;
                endcase
            end
            SUB_SHIFT: begin
                dec_e.result_valid = 1'b1;
                case (sel)
                    SEL_SLL: dec_e.result = rs1 << shamt;
                    SEL_SRL: dec_e.result = rs1 >> shamt;
                    SEL_SRA: dec_e.result = XLEN'($signed(rs1) >>> shamt);
                    default: dec_illegal = 1'b1;
                endcase
                dec_serial = SERIAL_SHIFT && !dec_illegal && (shamt != '0);
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_e         = '0;
            dec_e.rd      = rd_i;
            dec_e.illegal = 1'b1;
        end
    end

    always_comb begin
        case (sh_op)
            2'd0:    sh_step = {sh_val[XLEN-2:0], 1'b0};
            2'd1:    sh_step = {1'b0, sh_val[XLEN-1:1]};
            default: sh_step = {sh_val[XLEN-1], sh_val[XLEN-1:1]};
        endcase
    end

    // The final serial step is pushed directly, so a shift of N completes N cycles after accept.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        push_e  = dec_e;
        case (state_q)
            FSM_IDLE: begin
                if (accept) begin
                    if (dec_serial) state_d = FSM_SHIFT;
                    else            push    = 1'b1;
                end
            end
            FSM_SHIFT: begin
                push_e              = '0;
                push_e.result_valid = 1'b1;
                push_e.rd           = sh_rd;
                push_e.result       = sh_step;
                if (sh_cnt == SHW'(1)) begin
                    push    = 1'b1;
                    state_d = FSM_IDLE;
                end
            end
            default: state_d = FSM_IDLE;
        endcase
        if (flush) begin
            state_d = FSM_IDLE;
            push    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FSM_IDLE;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_val <= '0;
            sh_op  <= '0;
            sh_rd  <= '0;
            sh_cnt <= '0;
        end else if (state_q == FSM_IDLE) begin
            if (accept && dec_serial) begin
                sh_val <= rs1;
                sh_op  <= sel[1:0];
                sh_rd  <= rd_i;
                sh_cnt <= shamt;
            end
        end else begin
            sh_val <= sh_step;
            sh_cnt <= sh_cnt - SHW'(1);
        end
    end

    alu_out_queue #(
        .DEPTH   (OUT_DEPTH),
        .entry_t (alu_entry_t)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (push_e),
        .pop       (out_ready),
        .head      (head_e),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign out_valid    = ~q_empty;
    assign result       = out_valid ? head_e.result : '0;
    assign target       = out_valid ? head_e.target : '0;
    assign rd_o         = out_valid ? head_e.rd : '0;
    assign result_valid = out_valid & head_e.result_valid;
    assign target_valid = out_valid & head_e.target_valid;
    assign illegal      = out_valid & head_e.illegal;

endmodule

// File: tb/tb_alu_pipelined.sv
// Directed scoreboard bench for alu_pipelined (XLEN=32, OUT_DEPTH=2, serial shifter enabled).
module tb_alu_pipelined;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  unit;
    logic [2:0]  sub_unit;
    logic [3:0]  sel;
    logic [31:0] rs1, rs2, immediate, pc;
    logic        imm;
    logic [4:0]  rd_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        result_valid;
    logic [4:0]  rd_o;
    logic [31:0] target;
    logic        target_valid;
    logic        illegal;
    logic        flush;

    typedef struct {
        logic [31:0] result;
        logic [31:0] target;
        logic [4:0]  rd;
        logic        rv;
        logic        tv;
        logic        ill;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    alu_pipelined #(
        .XLEN         (32),
        .OUT_DEPTH    (2),
        .SERIAL_SHIFT (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .unit         (unit),
        .sub_unit     (sub_unit),
        .sel          (sel),
        .rs1          (rs1),
        .rs2          (rs2),
        .immediate    (immediate),
        .imm          (imm),
        .pc           (pc),
        .rd_i         (rd_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .result_valid (result_valid),
        .rd_o         (rd_o),
        .target       (target),
        .target_valid (target_valid),
        .illegal      (illegal),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic [31:0] t, input logic [4:0] d,
                                input logic rv, input logic tv, input logic ill);
        exp_t e;
        e = '{result: r, target: t, rd: d, rv: rv, tv: tv, ill: ill};
        return e;
    endfunction

    // Reference behaviour of one issued op.
    function automatic exp_t model(input logic [2:0] s, input logic [3:0] se, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] iv, input logic im,
                                   input logic [31:0] p, input logic [4:0] r);
        exp_t        e;
        logic [31:0] ob;
        logic [31:0] t;
        logic [4:0]  sh;
        logic        ok;
        logic        tk;
        e  = mk(32'd0, 32'd0, r, 1'b0, 1'b0, 1'b0);
        ob = im ? iv : b;
        sh = ob[4:0];
        ok = 1'b1;
        tk = 1'b0;
        case (s)
            3'd0: begin
                e.rv = 1'b1;
                case (se)
                    4'd0: e.result = iv;
                    4'd1: e.result = p + iv;
                    4'd2: begin e.result = p + 32'd4; e.target = p + iv; e.tv = 1'b1; end
                    4'd3: begin
                        t = a + iv;
                        e.result = p + 32'd4;
                        e.target = t & 32'hFFFF_FFFE;
                        e.tv = 1'b1;
                    end
                    default: ok = 1'b0;
                endcase
            end
            3'd1: begin
                case (se)
                    4'd0: tk = (a == b);
                    4'd1: tk = (a != b);
                    4'd2: tk = ($signed(a) < $signed(b));
                    4'd3: tk = !($signed(a) < $signed(b));
                    4'd4: tk = (a < b);
                    4'd5: tk = !(a < b);
                    default: ok = 1'b0;
                endcase
                if (tk) begin e.tv = 1'b1; e.target = p + iv; end
            end
            3'd2: begin
                e.rv = 1'b1;
                if (se == 4'd0) e.result = a + ob;
                else if (se == 4'd1 && !im) e.result = a + ~b + 32'd1;
                else ok = 1'b0;
            end
            3'd3: begin
                e.rv = 1'b1;
                case (se)
                    4'd0: e.result = ($signed(a) < $signed(ob)) ? 32'd1 : 32'd0;
                    4'd1: e.result = (a < ob) ? 32'd1 : 32'd0;
                    4'd2: e.result = a ^ ob;
                    4'd3: e.result = a | ob;
                    4'd4: e.result = a & ob;
                    default: ok = 1'b0;
                endcase
            end
            3'd4: begin
                e.rv = 1'b1;
                case (se)
                    4'd0: e.result = a << sh;
                    4'd1: e.result = a >> sh;
                    4'd2: e.result = $signed(a) >>> sh;
                    default: ok = 1'b0;
                endcase
            end
            default: ok = 1'b0;
        endcase
        if (!ok) e = mk(32'd0, 32'd0, r, 1'b0, 1'b0, 1'b1);
        return e;
    endfunction

    task automatic drive(input logic [2:0] s, input logic [3:0] se, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] iv, input logic im,
                         input logic [31:0] p, input logic [4:0] r);
        unit = 2'h0; sub_unit = s; sel = se; rs1 = a; rs2 = b;
        immediate = iv; imm = im; pc = p; rd_i = r; in_valid = 1'b1;
    endtask

    task automatic wait_accept(input string tag, input exp_t e);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            n++;
            if (n > 40) begin
                checks++;
                failures++;
                $error("FAIL %s_accept observed=timeout expected=in_ready", tag);
                in_valid = 1'b0;
                return;
            end
        end
        sbq.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic issue(input string tag, input logic [2:0] s, input logic [3:0] se,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] iv,
                         input logic im, input logic [31:0] p, input logic [4:0] r);
        drive(s, se, a, b, iv, im, p, r);
        wait_accept(tag, model(s, se, a, b, iv, im, p, r));
    endtask

    task automatic issue_e(input string tag, input exp_t e, input logic [2:0] s, input logic [3:0] se,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] iv,
                           input logic im, input logic [31:0] p, input logic [4:0] r);
        drive(s, se, a, b, iv, im, p, r);
        wait_accept(tag, e);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sbq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_output observed=result_%h expected=no_output", result);
            end else begin
                mon_e = sbq.pop_front();
                chk("result", result, mon_e.result);
                chk("target", target, mon_e.target);
                chk("rd_o", 32'(rd_o), 32'(mon_e.rd));
                chk1("result_valid", result_valid, mon_e.rv);
                chk1("target_valid", target_valid, mon_e.tv);
                chk1("illegal", illegal, mon_e.ill);
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; unit = 2'h0; sub_unit = '0; sel = '0;
        rs1 = '0; rs2 = '0; immediate = '0; imm = 1'b0; pc = '0; rd_i = '0;
        out_ready = 1'b1; flush = 1'b0;

        #3;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk("rst_result", result, 32'd0);
        chk("rst_target", target, 32'd0);
        chk("rst_rd_o", 32'(rd_o), 32'd0);
        chk1("rst_illegal", illegal, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("ready_after_reset", in_ready, 1'b1);
        chk1("empty_after_reset", out_valid, 1'b0);
        @(posedge clk);
        #1;

        issue_e("add_wrap", mk(32'd0, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0),
                3'd2, 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0, 5'd5);
        @(negedge clk);
        chk1("add_latency", out_valid, 1'b1);
        @(posedge clk);
        #1;

        issue_e("blt", mk(32'd0, 32'h120, 5'd3, 1'b0, 1'b1, 1'b0),
                3'd1, 4'd2, 32'h8000_0000, 32'd1, 32'h20, 1'b0, 32'h100, 5'd3);
        issue_e("bltu", mk(32'd0, 32'd0, 5'd3, 1'b0, 1'b0, 1'b0),
                3'd1, 4'd4, 32'h8000_0000, 32'd1, 32'h20, 1'b0, 32'h100, 5'd3);
        issue("add_imm", 3'd2, 4'd0, 32'd10, 32'd99, 32'hFFFF_FFFD, 1'b1, 32'd0, 5'd1);
        issue("sub", 3'd2, 4'd1, 32'd5, 32'd7, 32'd0, 1'b0, 32'd0, 5'd2);
        issue("sub_imm_illegal", 3'd2, 4'd1, 32'd5, 32'd7, 32'd1, 1'b1, 32'd0, 5'd2);
        issue("slt", 3'd3, 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0, 5'd4);
        issue("sltu", 3'd3, 4'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0, 5'd4);
        issue("xor", 3'd3, 4'd2, 32'hF0F0_1234, 32'd0, 32'h0FF0_FFFF, 1'b1, 32'd0, 5'd6);
        issue("or", 3'd3, 4'd3, 32'hF000_0001, 32'h0000_0F10, 32'd0, 1'b0, 32'd0, 5'd7);
        issue("and", 3'd3, 4'd4, 32'hF0F0_FFFF, 32'h3C3C_00FF, 32'd0, 1'b0, 32'd0, 5'd8);
        issue("lui", 3'd0, 4'd0, 32'd0, 32'd0, 32'h1234_5000, 1'b0, 32'h40, 5'd9);
        issue("auipc", 3'd0, 4'd1, 32'd0, 32'd0, 32'h0000_2000, 1'b0, 32'h1000, 5'd10);
        issue("jal", 3'd0, 4'd2, 32'd0, 32'd0, 32'h40, 1'b0, 32'h200, 5'd11);
        issue("jalr", 3'd0, 4'd3, 32'h303, 32'd0, 32'h10, 1'b0, 32'h200, 5'd12);
        issue("beq_imm_ignored", 3'd1, 4'd0, 32'd77, 32'd77, 32'h80, 1'b1, 32'h400, 5'd0);
        issue("bne", 3'd1, 4'd1, 32'd77, 32'd77, 32'h80, 1'b0, 32'h400, 5'd0);
        issue("bge", 3'd1, 4'd3, 32'd1, 32'h8000_0000, 32'hFFFF_FFF0, 1'b0, 32'h400, 5'd0);
        issue("bgeu", 3'd1, 4'd5, 32'd1, 32'h8000_0000, 32'h10, 1'b0, 32'h400, 5'd0);
        issue("sll_shamt0", 3'd4, 4'd0, 32'd5, 32'h20, 32'd0, 1'b0, 32'd0, 5'd13);
        issue("sll_serial1", 3'd4, 4'd0, 32'h4000_0001, 32'd0, 32'd1, 1'b1, 32'd0, 5'd14);
        issue("srl_serial3", 3'd4, 4'd1, 32'h80, 32'd3, 32'd0, 1'b0, 32'd0, 5'd15);
        issue("sub5_illegal", 3'd5, 4'd0, 32'd1, 32'd2, 32'd3, 1'b0, 32'd0, 5'd16);
        issue("branch_sel6_illegal", 3'd1, 4'd6, 32'd1, 32'd1, 32'd3, 1'b0, 32'd0, 5'd17);
        issue("shift_sel3_illegal", 3'd4, 4'd3, 32'd1, 32'd1, 32'd0, 1'b0, 32'd0, 5'd18);
        drain("drain_ops");

        drive(3'd2, 4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 32'd0, 5'd1);
        unit = 2'h1;
        repeat (3) @(negedge clk);
        chk1("other_unit_ignored", out_valid, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0; unit = 2'h0;

        issue_e("sra_serial", mk(32'hFF00_0000, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0),
                3'd4, 4'd2, 32'hF000_0000, 32'd0, 32'd4, 1'b1, 32'd0, 5'd7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("serial_busy_ready", in_ready, 1'b0);
            chk1("serial_busy_valid", out_valid, 1'b0);
        end
        @(negedge clk);
        chk1("serial_done_valid", out_valid, 1'b1);
        chk1("serial_done_ready", in_ready, 1'b1);
        drain("drain_serial");

        out_ready = 1'b0;
        issue("fifo_a", 3'd2, 4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 32'd0, 5'd20);
        issue("fifo_b", 3'd2, 4'd0, 32'd10, 32'd20, 32'd0, 1'b0, 32'd0, 5'd21);
        drive(3'd2, 4'd0, 32'd100, 32'd200, 32'd0, 1'b0, 32'd0, 5'd22);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk1("full_in_ready", in_ready, 1'b0);
            chk1("full_out_valid", out_valid, 1'b1);
            chk("full_head_stable", result, 32'd3);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_accept("fifo_c", model(3'd2, 4'd0, 32'd100, 32'd200, 32'd0, 1'b0, 32'd0, 5'd22));
        drain("drain_fifo");

        out_ready = 1'b0;
        issue("flush_x", 3'd2, 4'd0, 32'd4, 32'd4, 32'd0, 1'b0, 32'd0, 5'd23);
        issue("flush_sra", 3'd4, 4'd2, 32'hF000_0000, 32'd0, 32'd4, 1'b1, 32'd0, 5'd24);
        @(negedge clk);
        chk1("shifting_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk1("flush_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 flush = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk1("flush_out_valid", out_valid, 1'b0);
        chk1("flush_fsm_idle", in_ready, 1'b1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk1("flush_no_late_push", out_valid, 1'b0);
        @(posedge clk);
        #1;
        issue("post_flush_add", 3'd2, 4'd0, 32'd8, 32'd9, 32'd0, 1'b0, 32'd0, 5'd25);
        @(negedge clk);
        chk1("post_flush_latency", out_valid, 1'b1);
        drain("drain_flush");

        out_ready = 1'b0;
        issue("rst_jal", 3'd0, 4'd2, 32'd0, 32'd0, 32'h40, 1'b0, 32'h200, 5'd9);
        issue("rst_add", 3'd2, 4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 32'd0, 5'd3);
        @(negedge clk);
        chk1("pre_reset_target_valid", target_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("async_out_valid", out_valid, 1'b0);
        chk1("async_result_valid", result_valid, 1'b0);
        chk1("async_target_valid", target_valid, 1'b0);
        chk1("async_illegal", illegal, 1'b0);
        chk("async_result", result, 32'd0);
        chk("async_target", target, 32'd0);
        chk("async_rd_o", 32'(rd_o), 32'd0);
        chk1("async_in_ready", in_ready, 1'b0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk1("rerst_in_ready", in_ready, 1'b1);
        chk1("rerst_out_valid", out_valid, 1'b0);
        chk("final_scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
